adder_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 64-bit ripple-carry adder datapath among NREQ requesters. Each requester raises a request with its two operands. The block grants one requester at a time, latches its operands into the adder, and registers the sum and carry-out. It then returns the result on a shared result bus with a one-cycle done pulse addressed to the granted requester. It sits between the execution units that need occasional wide additions and the single shared adder instance.

---
 rtl/adder_share_arbiter.sv | 163 ++++++++++++++++
 tb/tb_adder_share_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one WIDTH-bit ripple-carry adder among
// NREQ requesters; each operation runs IDLE -> CALC -> RESP with registered outputs.
module adder_share_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*WIDTH-1:0]      op_a,
  input  logic [NREQ*WIDTH-1:0]      op_b,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            done,
  output logic [WIDTH-1:0]           result,
  output logic                       carry_out,
  output logic [$clog2(NREQ)-1:0]    result_id,
  output logic                       busy
);

  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q;
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     ptr_d;
  logic [IDW-1:0]     id_q;
  logic [WIDTH-1:0]   opa_q;
  logic [WIDTH-1:0]   opb_q;
  logic [NREQ-1:0]    gnt_q;
  logic [NREQ-1:0]    done_q;
  logic [WIDTH-1:0]   result_q;
  logic               carry_q;
  logic [IDW-1:0]     result_id_q;
  logic               busy_q;

  // Round-robin search state
  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic [NREQ-1:0]    win_oh;
  logic [NREQ-1:0]    id_oh;
  logic [WIDTH-1:0]   opa_sel;
  logic [WIDTH-1:0]   opb_sel;
  int unsigned        cand;
  logic [IDW-1:0]     cand_idx;

  // Shared ripple-carry adder
  logic [WIDTH-1:0]   sum;
  logic [WIDTH:1]     cy;

  // Search begins at ptr_q and wraps; first asserted request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand     = (int'(ptr_q) + k) % NREQ;
      cand_idx = IDW'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    win_oh  = '0;
    id_oh   = '0;
    opa_sel = '0;
    opb_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_found && (win_idx == IDW'(i))) begin
        win_oh[i] = 1'b1;
        opa_sel   = op_a[i*WIDTH +: WIDTH];
        opb_sel   = op_b[i*WIDTH +: WIDTH];
      end
      if (id_q == IDW'(i)) begin
        id_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    if (id_q == IDW'(NREQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = id_q + 1'b1;
    end
  end

  // Bit 0 is a half adder (carry-in is tied to zero); full adders above it.
  assign sum[0] = opa_q[0] ^ opb_q[0];
  assign cy[1]  = opa_q[0] & opb_q[0];

  genvar g;
  generate
    for (g = 1; g < WIDTH; g++) begin : g_fa
      logic p;
      assign p       = opa_q[g] ^ opb_q[g];
      assign sum[g]  = p ^ cy[g];
      assign cy[g+1] = (opa_q[g] & opb_q[g]) | (cy[g] & p);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      result_id_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            opa_q   <= opa_sel;
            opb_q   <= opb_sel;
            id_q    <= win_idx;
            gnt_q   <= win_oh;
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          result_q    <= sum;
          carry_q     <= cy[WIDTH];
          result_id_q <= id_q;
          done_q      <= id_oh;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          done_q  <= '0;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= ptr_d;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign result_id = result_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: a scoreboard queue holds expected
// (id, sum, carry) entries, popped and compared whenever done pulses.
module tb_adder_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 64;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] op_a;
  logic [NREQ*W-1:0] op_b;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      result;
  logic              carry_out;
  logic [1:0]        result_id;
  logic              busy;

  adder_share_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .gnt       (gnt),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .result_id (result_id),
    .busy      (busy)
  );

  typedef struct {
    int         id;
    logic [W-1:0] sum;
    logic       c;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[idx*W +: W] = a;
    op_b[idx*W +: W] = b;
  endtask

  task automatic push(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0] s;
    s     = {1'b0, a} + {1'b0, b};
    e.id  = idx;
    e.sum = s[W-1:0];
    e.c   = s[W];
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      tick();
      if (done !== '0) seen = 1'b1;
    end
    check(tag, seen, 1);
  endtask

  task automatic run_one(input int idx, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    set_ops(idx, a, b);
    req = 4'b0001 << idx;
    push(idx, a, b);
    wait_done(tag);
    req = '0;
    tick();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},    gnt, 0);
    check({tag, "_done"},   done, 0);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_carry"},  carry_out, 0);
    check({tag, "_rid"},    result_id, 0);
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done !== '0) begin
      if (sb.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        exp_t e;
        logic [NREQ-1:0] oh;
        e  = sb.pop_front();
        oh = 4'b0001 << e.id;
        check("sb_done_onehot", done, oh);
        check("sb_gnt",         gnt, oh);
        check("sb_busy",        busy, 1);
        check("sb_result",      result, e.sum);
        check("sb_carry",       carry_out, e.c);
        check("sb_result_id",   result_id, e.id);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    op_a = '0;
    op_b = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Single request from requester 1
    set_ops(1, 64'd5, 64'd7);
    req = 4'b0010;
    push(1, 64'd5, 64'd7);
    tick();
    check("t1_gnt",  gnt, 4'b0010);
    check("t1_busy", busy, 1);
    check("t1_nodone", done, 0);
    tick();
    check("t1_done",   done, 4'b0010);
    check("t1_result", result, 12);
    check("t1_carry",  carry_out, 0);
    check("t1_rid",    result_id, 1);
    req = '0;
    tick();
    check("t1_gnt_clr",  gnt, 0);
    check("t1_done_clr", done, 0);
    check("t1_busy_clr", busy, 0);
    check("t1_result_hold", result, 12);
    tick();

    // All four requesters held high from reset: order 0,1,2,3,0, done every 3 cycles
    rst = 1'b1;
    set_ops(0, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111);
    set_ops(1, 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000);
    set_ops(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001);
    set_ops(3, 64'hDEAD_BEEF_CAFE_F00D, 64'h2152_4110_3501_0FF3);
    req = 4'b1111;
    tick();
    check_all_zero("rst2");
    push(0, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111);
    push(1, 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000);
    push(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001);
    push(3, 64'hDEAD_BEEF_CAFE_F00D, 64'h2152_4110_3501_0FF3);
    push(0, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111);
    rst = 1'b0;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      tick();
      check($sformatf("t2_done_cadence_c%0d", cyc), (done !== '0), ((cyc % 3) == 2));
    end
    req = '0;
    tick();
    tick();
    check("t2_sb_drained", sb.size(), 0);

    // Overflow / wrap cases
    run_one(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "t3_ovf_ones");
    run_one(3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, "t3_ovf_msb");
    run_one(1, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, "t3_all_ones");

    // Operand change and req drop after grant (ptr ends at 3)
    set_ops(2, 64'd10, 64'h1234);
    req = 4'b0100;
    push(2, 64'd10, 64'h1234);
    tick();
    check("t4_gnt", gnt, 4'b0100);
    set_ops(2, 64'd99, 64'h1234);
    req = '0;
    tick();
    check("t4_done",   done, 4'b0100);
    check("t4_result", result, 64'h123E);
    tick();
    tick();

    // Reset during CALC discards the operation and clears ptr
    set_ops(0, 64'd1, 64'd2);
    req = 4'b0001;
    tick();
    check("t5_gnt", gnt, 4'b0001);
    check("t5_busy", busy, 1);
    rst = 1'b1;
    req = '0;
    tick();
    check_all_zero("t5_midrst");
    rst = 1'b0;
    tick();
    check("t5_no_done", done, 0);
    set_ops(0, 64'h55, 64'h66);
    set_ops(3, 64'h77, 64'h88);
    req = 4'b1001;
    push(0, 64'h55, 64'h66);
    push(3, 64'h77, 64'h88);
    wait_done("t5_first");
    check("t5_first_id", result_id, 0);
    req = 4'b1000;
    wait_done("t5_second");
    check("t5_second_id", result_id, 3);
    req = '0;
    tick();
    tick();

    // Fairness: requester 0 held, requester 3 raises once
    set_ops(0, 64'hAAAA, 64'h5555);
    set_ops(3, 64'h1_0000_0000, 64'h2);
    req = 4'b0001;
    push(0, 64'hAAAA, 64'h5555);
    wait_done("t6_op0");
    req = 4'b1001;
    push(3, 64'h1_0000_0000, 64'h2);
    wait_done("t6_op1");
    check("t6_op1_id", result_id, 3);
    req = 4'b0001;
    push(0, 64'hAAAA, 64'h5555);
    wait_done("t6_op2");
    req = '0;
    tick();
    tick();
    tick();
    check("final_sb_empty", sb.size(), 0);
    check("final_idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
